// File: rtl/clarvi_fetch_pkg.sv
// Shared types for the Clarvi instruction-fetch stage: request FSM states,
// the instruction/PC entry held for decode, and PC alignment.
package clarvi_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_RESP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] target);
    return {target[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/clarvi_fetch_if.sv
// Instruction-bus read port: fetch stage is master, instruction memory is slave.
interface clarvi_fetch_if #(
  parameter int ADDR_WIDTH = 30
) ();

  logic [ADDR_WIDTH-1:0] instr_address;
  logic                  instr_read_enable;
  logic                  instr_wait;
  logic [31:0]           instr_read_data;
  logic                  instr_read_data_valid;

  modport master (
    output instr_address,
    output instr_read_enable,
    input  instr_wait,
    input  instr_read_data,
    input  instr_read_data_valid
  );

  modport slave (
    input  instr_address,
    input  instr_read_enable,
    output instr_wait,
    output instr_read_data,
    output instr_read_data_valid
  );

endinterface

// File: rtl/clarvi_fetch_buffer.sv
// Two-slot holding register: the entry presented to decode plus one
// prefetched entry behind it, with load, consume (via stall) and flush.
module clarvi_fetch_buffer
  import clarvi_fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         stall,
  input  logic         load,
  input  fetch_entry_t load_entry,
  output logic         out_valid,
  output logic         buf_valid,
  output fetch_entry_t out_entry
);

  fetch_entry_t buf_entry;
  logic         advance;

  // The output slot may take new contents when it is empty or being consumed.
  assign advance = !out_valid || !stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      buf_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      buf_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= buf_valid || load;
      buf_valid <= buf_valid && load;
    end else if (load) begin
      buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_entry <= '0;
    end else if (!flush && advance) begin
      if (buf_valid) out_entry <= buf_entry;
      else if (load) out_entry <= load_entry;
    end
  end

  // Prefetch slot data is qualified by buf_valid, so it needs no reset.
  always_ff @(posedge clock) begin
    if (load && (!advance || buf_valid)) buf_entry <= load_entry;
  end

endmodule

// File: rtl/clarvi_fetch.sv
// Clarvi instruction-fetch stage: one outstanding 32-bit read, output plus
// one-entry prefetch for the 4-cycle part-serialised decode, branch redirect.
module clarvi_fetch
  import clarvi_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          ADDR_WIDTH = 30
) (
  input  logic                  clock,
  input  logic                  reset_n,
  clarvi_fetch_if.master        ibus,
  input  logic                  stall_stage,
  input  logic                  branch_taken,
  input  logic [63:0]           branch_target,
  output logic [31:0]           in_instr,
  output logic [63:0]           if_de_pc,
  output logic                  stage_invalid
);

  fetch_state_t state, state_next;
  logic [63:0]  pc_next, req_pc, issue_pc;
  logic         drop;
  logic         issue, accept, resp_done, deliver;
  logic         out_valid, buf_valid;
  fetch_entry_t out_entry, resp_entry;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= F_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      F_IDLE:  if (branch_taken || !(out_valid && buf_valid)) state_next = F_REQ;
      F_REQ:   if (!ibus.instr_wait) state_next = F_RESP;
      F_RESP:  if (ibus.instr_read_data_valid) state_next = F_IDLE;
      default: state_next = F_IDLE;
    endcase
  end

  always_comb begin
    issue                  = 1'b0;
    accept                 = 1'b0;
    resp_done              = 1'b0;
    ibus.instr_read_enable = 1'b0;
    case (state)
      F_IDLE: issue = (state_next == F_REQ);
      F_REQ: begin
        ibus.instr_read_enable = 1'b1;
        accept                 = !ibus.instr_wait;
      end
      F_RESP:  resp_done = ibus.instr_read_data_valid;
      default: ;
    endcase
  end

  // A redirect seen while idle is issued straight away at the target.
  assign issue_pc           = branch_taken ? align_pc(branch_target) : pc_next;
  assign ibus.instr_address = req_pc[ADDR_WIDTH+1:2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_next <= RESET_PC;
      req_pc  <= RESET_PC;
      drop    <= 1'b0;
    end else begin
      if (issue) begin
        req_pc  <= issue_pc;
        pc_next <= issue_pc + 64'd4;
      end else if (branch_taken) begin
        pc_next <= align_pc(branch_target);
      end
      // A read already requested or in flight at redirect time is stale.
      if (resp_done)                           drop <= 1'b0;
      else if (branch_taken && (accept || state != F_IDLE)) drop <= 1'b1;
    end
  end

  assign deliver    = resp_done && !drop && !branch_taken;
  assign resp_entry = '{instr: ibus.instr_read_data, pc: req_pc};

  clarvi_fetch_buffer u_buffer (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (branch_taken),
    .stall      (stall_stage),
    .load       (deliver),
    .load_entry (resp_entry),
    .out_valid  (out_valid),
    .buf_valid  (buf_valid),
    .out_entry  (out_entry)
  );

  assign in_instr      = out_entry.instr;
  assign if_de_pc      = out_entry.pc;
  assign stage_invalid = !out_valid;

endmodule

// File: tb/tb_clarvi_fetch.sv
// Bench for clarvi_fetch: directed scenarios plus a randomized run checked
// against a program-order model of the instruction stream seen by decode.
module tb_clarvi_fetch;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          AW     = 30;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall_stage, branch_taken;
  logic [63:0] branch_target;
  logic [31:0] in_instr;
  logic [63:0] if_de_pc;
  logic        stage_invalid;

  clarvi_fetch_if #(.ADDR_WIDTH(AW)) ibus ();

  clarvi_fetch #(.RESET_PC(RST_PC), .ADDR_WIDTH(AW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ibus          (ibus),
    .stall_stage   (stall_stage),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .in_instr      (in_instr),
    .if_de_pc      (if_de_pc),
    .stage_invalid (stage_invalid)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // memory model state
  bit          rand_mode = 1'b0;
  int          lat_cfg = 1;
  int          wait_once = 0;
  bit          req_active = 1'b0;
  logic [AW-1:0] held_addr;
  int          wait_left;
  bit          pend = 1'b0;
  int          pend_cnt, pend_lat;
  logic [AW-1:0] pend_addr;
  int          accepts = 0;
  logic [AW-1:0] last_acc = '0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a, 2'b00} ^ 32'h0000_1013;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    stall_stage   = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    repeat (3) step();
    chk("reset_state", {stage_invalid, ibus.instr_read_enable, in_instr, if_de_pc},
        {1'b1, 1'b0, 32'h0, 64'h0});
    reset_n = 1'b1;
  endtask

  // Instruction memory: variable wait states, read latency >= 1 cycle.
  initial begin
    ibus.instr_wait            = 1'b0;
    ibus.instr_read_data       = '0;
    ibus.instr_read_data_valid = 1'b0;
    forever begin
      @(negedge clock);
      ibus.instr_read_data_valid = 1'b0;
      ibus.instr_read_data       = $urandom;
      if (!reset_n) begin
        pend            = 1'b0;
        req_active      = 1'b0;
        ibus.instr_wait = 1'b0;
      end else begin
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            pend                       = 1'b0;
            ibus.instr_read_data_valid = 1'b1;
            ibus.instr_read_data       = mem_word(pend_addr);
          end
        end
        if (req_active)
          chk("req_hold", {ibus.instr_read_enable, ibus.instr_address}, {1'b1, held_addr});
        if (ibus.instr_read_enable) begin
          if (!req_active) begin
            req_active = 1'b1;
            held_addr  = ibus.instr_address;
            if (wait_once > 0) begin
              wait_left = wait_once;
              wait_once = 0;
            end else begin
              wait_left = rand_mode ? int'($urandom_range(0, 3)) : 0;
            end
          end
          if (wait_left > 0) begin
            ibus.instr_wait = 1'b1;
            wait_left--;
          end else begin
            ibus.instr_wait = 1'b0;
            req_active      = 1'b0;
            pend            = 1'b1;
            pend_lat        = rand_mode ? int'($urandom_range(1, 3)) : lat_cfg;
            pend_cnt        = pend_lat;
            pend_addr       = ibus.instr_address;
            last_acc        = ibus.instr_address;
            accepts++;
          end
        end else begin
          ibus.instr_wait = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_pc, prev_pc, tgt;
    logic [31:0] prev_instr;
    bit          found, br, st, prev_valid, prev_stall, prev_branch;
    int          acc0, steps, nconsumed;

    // Fill from reset, then decode consuming every 4th cycle.
    lat_cfg = 1;
    do_reset();
    step();
    chk("t1_first_req", {ibus.instr_read_enable, ibus.instr_address}, {1'b1, 30'h400});
    step();
    chk("t1_fill_invalid", stage_invalid, 1'b1);
    step();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      exp_pc = RST_PC + 64'(4 * (k / 4));
      chk("t2_hold4", {stage_invalid, if_de_pc, in_instr}, {1'b0, exp_pc, mem_word(exp_pc[31:2])});
      stall_stage = (k % 4 != 3);
    end

    // Five wait-state cycles on the first request.
    wait_once = 5;
    acc0 = accepts;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("t3_req_stable", {ibus.instr_read_enable, ibus.instr_address}, {1'b1, 30'h400});
    end
    step();
    chk("t3_one_accept", accepts - acc0, 1);
    step();
    chk("t3_data", {stage_invalid, if_de_pc, in_instr}, {1'b0, RST_PC, 32'h13});
    chk("t3_accepts", accepts - acc0, 1);

    // Redirect while the 0x1008 read is in flight.
    lat_cfg = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (pend && pend_addr == 30'h402 && pend_cnt < pend_lat) found = 1'b1;
      else stall_stage = !(!stage_invalid && if_de_pc == 64'h1000);
    end
    chk("t4_reach_resp", found, 1'b1);
    branch_taken  = 1'b1;
    branch_target = 64'h2003;
    stall_stage   = 1'b1;
    step();
    branch_taken = 1'b0;
    chk("t4_squash", stage_invalid, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (!stage_invalid) found = 1'b1;
    end
    chk("t4_target", {found, if_de_pc, in_instr}, {1'b1, 64'h2000, mem_word(30'h800)});

    // Redirect coinciding with returning data and a consume.
    lat_cfg = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (!stage_invalid && ibus.instr_read_data_valid) found = 1'b1;
    end
    chk("t5_setup", found, 1'b1);
    acc0          = accepts;
    branch_taken  = 1'b1;
    branch_target = 64'h3001;
    stall_stage   = 1'b0;
    step();
    branch_taken = 1'b0;
    stall_stage  = 1'b1;
    chk("t5_flush", stage_invalid, 1'b1);
    steps = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      steps++;
      if (!stage_invalid) found = 1'b1;
    end
    chk("t5_target", {found, if_de_pc, in_instr, last_acc},
        {1'b1, 64'h3000, mem_word(30'hC00), 30'hC00});
    chk("t5_latency", steps >= 3, 1'b1);
    chk("t5_single_fetch", accepts - acc0, 1);

    // Asynchronous reset while holding 0x1004 with a prefetch pending.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (!stage_invalid && if_de_pc == 64'h1004 && ibus.instr_read_enable) found = 1'b1;
      else stall_stage = !(!stage_invalid && if_de_pc == 64'h1000);
    end
    chk("t6_setup", found, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t6_async_reset", {stage_invalid, ibus.instr_read_enable, in_instr, if_de_pc},
        {1'b1, 1'b0, 32'h0, 64'h0});
    repeat (2) step();
    reset_n     = 1'b1;
    stall_stage = 1'b1;
    step();
    chk("t6_restart_req", {ibus.instr_read_enable, ibus.instr_address}, {1'b1, 30'h400});
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (!stage_invalid) found = 1'b1;
    end
    chk("t6_restart_data", {found, if_de_pc, in_instr}, {1'b1, RST_PC, 32'h13});

    // Randomized run: consumed instructions must follow program order.
    rand_mode = 1'b1;
    do_reset();
    exp_pc      = RST_PC;
    tgt         = '0;
    prev_valid  = 1'b0;
    prev_stall  = 1'b0;
    prev_branch = 1'b0;
    prev_pc     = '0;
    prev_instr  = '0;
    nconsumed   = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (prev_branch)
        chk("rnd_flush", stage_invalid, 1'b1);
      else if (prev_valid && prev_stall)
        chk("rnd_hold", {stage_invalid, if_de_pc, in_instr}, {1'b0, prev_pc, prev_instr});
      br = ($urandom_range(0, 99) < 4);
      st = ($urandom_range(0, 99) < 55);
      if (!stage_invalid && !br && !st) begin
        chk("rnd_consume", {if_de_pc, in_instr}, {exp_pc, mem_word(exp_pc[31:2])});
        exp_pc = exp_pc + 64'd4;
        nconsumed++;
      end
      prev_valid  = !stage_invalid;
      prev_pc     = if_de_pc;
      prev_instr  = in_instr;
      prev_stall  = st;
      prev_branch = br;
      if (br) begin
        case ($urandom_range(0, 2))
          0:       tgt = {32'h0, $urandom};
          1:       tgt = {$urandom, $urandom};
          default: tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        endcase
        exp_pc = {tgt[63:2], 2'b00};
      end
      branch_taken  = br;
      branch_target = tgt;
      stall_stage   = st;
    end
    branch_taken = 1'b0;
    chk("rnd_progress", nconsumed > 200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
